hilo_mdu: RTL and testbench
===========================

# hilo_mdu

Execute-stage multiply/divide unit and HI/LO register file for the MIPS pipeline. It consumes the registered `aluopE` code produced by the ALU decoder and executes `ALUOP_MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO`, where all codes come from `defines.vh`. Multiplies and moves complete in one cycle. Divides run an iterative radix-2 divider and stall the pipeline until the quotient and remainder are ready. HI/LO are architectural state, read back by MFHI/MFLO through `mdu_resultE`.

## Interface
Parameters:
- `DIV_ITERS`, default 32: number of divider iteration cycles (one quotient bit per cycle).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `aluopE`  in  8  ALU op of the EX-stage instruction.
- `srcaE`  in  32  rs operand: dividend, multiplicand, or MTHI/MTLO data.
- `srcbE`  in  32  rt operand: divisor or multiplier.
- `stallE`  in  1  external EX stall from other hazards; excludes this block's own stall.
- `killE`  in  1  the EX instruction must not commit (exception/flush); aborts a divide.
- `stall_divE`  out  1  divide in progress; hazard unit stalls F/D/E.
- `mdu_resultE`  out  32  HI for MFHI, LO for MFLO, otherwise 0.
- `hi_o`  out  32  current HI.
- `lo_o`  out  32  current LO.

## Operation
- State machine `IDLE`, `BUSY`, `DONE`. Iteration counter `cnt` is 6 bits.
- Let `commit = ~stallE & ~killE`.
- IDLE:
  - MULT: {HI,LO} <= signed 64-bit product at the edge if commit.
  - MULTU: {HI,LO} <= unsigned 64-bit product at the edge if commit.
  - MTHI: HI <= srcaE if commit. MTLO: LO <= srcaE if commit.
  - DIV/DIVU, ~killE, srcbE != 0: latch |dividend| and |divisor| (magnitudes for DIV, raw values for DIVU); latch sign flags; cnt <= 0; go to BUSY.
  - DIV/DIVU, srcbE == 0: no stall. At the edge if commit, HI <= srcaE and LO <= 32'hFFFFFFFF.
- BUSY: one restoring-division step per cycle on a 64-bit remainder/quotient shift register; cnt++. After `DIV_ITERS` steps, go to DONE.
- DONE: apply signs.
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the dividend's sign (DIV only).
  - If commit: LO <= quotient, HI <= remainder, go to IDLE.
  - If stallE: hold in DONE with the result unchanged.
- killE in BUSY or DONE: return to IDLE next edge; HI/LO unchanged.
- 0x80000000 / 0xFFFFFFFF (DIV) gives LO = 0x80000000, HI = 0. This follows from the 32-bit magnitude arithmetic; no special case.
- `stall_divE` is asserted:
  - combinationally in IDLE when aluopE is DIV/DIVU, srcbE != 0 and ~killE;
  - throughout BUSY;
  - deasserted in DONE.
- `mdu_resultE` is combinational from the HI/LO registers. An MFHI/MFLO in EX the cycle after a HI/LO write sees the new value; no forwarding is needed.
- Any other aluopE: no state change; `mdu_resultE` = 0.

## Timing
- Reset: state IDLE, cnt = 0, HI = 0, LO = 0, `stall_divE` = 0, `mdu_resultE` = 0. Reset takes effect mid-divide; no HI/LO write.
- MULT/MULTU/MTHI/MTLO: result visible on `hi_o`/`lo_o` the cycle after the op is in EX with commit.
- DIV/DIVU, nonzero divisor:
  - cycle 0: op enters EX, `stall_divE` = 1;
  - cycles 1..32: BUSY, `stall_divE` = 1;
  - cycle 33: DONE, `stall_divE` = 0;
  - HI/LO written at the end of cycle 33.
  - `stall_divE` is high for exactly 33 cycles.
- Back-to-back DIVs: the second starts in the cycle after DONE commits, with no bubble beyond its own stall.
- DONE with stallE = 1 for N cycles: DONE is extended N cycles; HI/LO are written once.

## Test plan
- MULT srca = 0xFFFFFFFF, srcb = 2 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFE next cycle, `stall_divE` never high. MULTU with the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, `stall_divE` high exactly 33 cycles. DIVU 7 / 2 → LO = 3, HI = 1.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. DIVU 0x1234 / 0 → no stall, HI = 0x1234, LO = 0xFFFFFFFF.
- DIV started, killE = 1 at BUSY iteration 10 → `stall_divE` low the next cycle, state IDLE, HI/LO unchanged. Repeat with rst instead of killE → HI = LO = 0.
- MTHI 0x00001234, then MFHI in the following cycle → `mdu_resultE` = 0x00001234. MTLO with killE = 1 → LO unchanged.
- DIVU 100 / 7 with stallE = 1 for 3 cycles starting at DONE → DONE held 4 cycles, single write LO = 14, HI = 2, `stall_divE` low throughout DONE.

Source files
------------

// File: rtl/hilo_mdu.sv
// hilo_mdu: execute-stage multiply/divide unit and HI/LO register file.
// Multiplies and HI/LO moves finish in one cycle. Divides use a radix-2
// restoring divider and hold stall_divE until DONE. The ALUOP_* parameters
// carry the ALU decoder encodings and can be overridden to match them.
module hilo_mdu #(
    parameter int         DIV_ITERS   = 32,
    parameter logic [7:0] ALUOP_MFHI  = 8'h10,
    parameter logic [7:0] ALUOP_MTHI  = 8'h11,
    parameter logic [7:0] ALUOP_MFLO  = 8'h12,
    parameter logic [7:0] ALUOP_MTLO  = 8'h13,
    parameter logic [7:0] ALUOP_MULT  = 8'h18,
    parameter logic [7:0] ALUOP_MULTU = 8'h19,
    parameter logic [7:0] ALUOP_DIV   = 8'h1A,
    parameter logic [7:0] ALUOP_DIVU  = 8'h1B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluopE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        stallE,
    input  logic        killE,
    output logic        stall_divE,
    output logic [31:0] mdu_resultE,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] rq_q, rq_d;       // {remainder, quotient/dividend} shift register
    logic [31:0] dvsr_q, dvsr_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        commit;
    logic        is_div;
    logic        signed_div;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod_s, prod_u;
    logic [32:0] part, diff;
    logic [31:0] q_fin, r_fin;

    // Operand conditioning, products, one divider step and sign fix-up
    always_comb begin
        commit     = ~stallE & ~killE;
        is_div     = (aluopE == ALUOP_DIV) || (aluopE == ALUOP_DIVU);
        signed_div = (aluopE == ALUOP_DIV);
        a_mag      = (signed_div && srcaE[31]) ? -srcaE : srcaE;
        b_mag      = (signed_div && srcbE[31]) ? -srcbE : srcbE;
        // Low 64 bits of the product of sign-extended operands are the signed product.
        prod_s     = {{32{srcaE[31]}}, srcaE} * {{32{srcbE[31]}}, srcbE};
        prod_u     = {32'd0, srcaE} * {32'd0, srcbE};
        // Partial remainder after shifting in the next dividend bit; needs 33 bits.
        part       = {rq_q[63:32], rq_q[31]};
        diff       = part - {1'b0, dvsr_q};
        q_fin      = qneg_q ? -rq_q[31:0] : rq_q[31:0];
        r_fin      = rneg_q ? -rq_q[63:32] : rq_q[63:32];
    end

    // Next-state, HI/LO update and stall generation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rq_d       = rq_q;
        dvsr_d     = dvsr_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        stall_divE = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_div) begin
                    if (srcbE != 32'd0) begin
                        if (!killE) begin
                            stall_divE = 1'b1;
                            rq_d       = {32'd0, a_mag};
                            dvsr_d     = b_mag;
                            qneg_d     = signed_div & (srcaE[31] ^ srcbE[31]);
                            rneg_d     = signed_div & srcaE[31];
                            cnt_d      = 6'd0;
                            state_d    = BUSY;
                        end
                    end else if (commit) begin
                        // Divide by zero: no stall, fixed architectural result.
                        hi_d = srcaE;
                        lo_d = 32'hFFFF_FFFF;
                    end
                end else if (commit) begin
                    if (aluopE == ALUOP_MULT)  {hi_d, lo_d} = prod_s;
                    if (aluopE == ALUOP_MULTU) {hi_d, lo_d} = prod_u;
                    if (aluopE == ALUOP_MTHI)  hi_d = srcaE;
                    if (aluopE == ALUOP_MTLO)  lo_d = srcaE;
                end
            end
            BUSY: begin
                stall_divE = 1'b1;
                if (killE) begin
                    state_d = IDLE;
                end else begin
                    if (!diff[32]) rq_d = {diff[31:0], rq_q[30:0], 1'b1};
                    else           rq_d = {part[31:0], rq_q[30:0], 1'b0};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) state_d = DONE;
                end
            end
            DONE: begin
                if (killE) begin
                    state_d = IDLE;
                end else if (!stallE) begin
                    lo_d    = q_fin;
                    hi_d    = r_fin;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read port: MFHI/MFLO see the registered HI/LO directly
    always_comb begin
        mdu_resultE = 32'd0;
        if (aluopE == ALUOP_MFHI) mdu_resultE = hi_q;
        if (aluopE == ALUOP_MFLO) mdu_resultE = lo_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            rq_q    <= 64'd0;
            dvsr_q  <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rq_q    <= rq_d;
            dvsr_q  <= dvsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed and randomized checks of hilo_mdu against a
// behavioural HI/LO model using plain 64-bit arithmetic.
module tb_hilo_mdu;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluopE = OP_NOP;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        stallE = 1'b0;
    logic        killE = 1'b0;
    logic        stall_divE;
    logic [31:0] mdu_resultE, hi_o, lo_o;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    hilo_mdu dut (
        .clk(clk), .rst(rst), .aluopE(aluopE), .srcaE(srcaE), .srcbE(srcbE),
        .stallE(stallE), .killE(killE), .stall_divE(stall_divE),
        .mdu_resultE(mdu_resultE), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of a committed op on HI/LO
    task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
            OP_MTHI:  hi_m = a;
            OP_MTLO:  lo_m = a;
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    hi_m = a; lo_m = 32'hFFFF_FFFF;
                end else if (op == OP_DIV) begin
                    q = sa / sb; r = sa % sb;
                    lo_m = 32'(q); hi_m = 32'(r);
                end else begin
                    lo_m = a / b; hi_m = a % b;
                end
            end
            default: ;
        endcase
    endtask

    // Single-cycle op (including divide by zero): never stalls
    task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic kill);
        logic [31:0] exp_res;
        aluopE = op; srcaE = a; srcbE = b; killE = kill;
        #1;
        exp_res = (op == OP_MFHI) ? hi_m : (op == OP_MFLO) ? lo_m : 32'd0;
        chk("op_stall", stall_divE, 1'b0);
        chk("op_result", mdu_resultE, exp_res);
        step();
        aluopE = OP_NOP; killE = 1'b0;
        if (!kill) model(op, a, b);
        #1;
        chk("op_hi", hi_o, hi_m);
        chk("op_lo", lo_o, lo_m);
    endtask

    // Nonzero-divisor divide, optional external stall while in DONE
    task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        int n;
        aluopE = op; srcaE = a; srcbE = b;
        #1;
        n = 0;
        while (stall_divE && n < 100) begin
            n++;
            step();
        end
        chk("div_stall_cycles", n, 33);
        chk("div_done_hi_held", hi_o, hi_m);
        chk("div_done_lo_held", lo_o, lo_m);
        stallE = (hold > 0);
        repeat (hold) begin
            #1;
            chk("div_hold_stall", stall_divE, 1'b0);
            step();
            chk("div_hold_hi", hi_o, hi_m);
            chk("div_hold_lo", lo_o, lo_m);
        end
        stallE = 1'b0;
        #1;
        chk("div_done_stall", stall_divE, 1'b0);
        step();
        aluopE = OP_NOP;
        model(op, a, b);
        #1;
        chk("div_hi", hi_o, hi_m);
        chk("div_lo", lo_o, lo_m);
    endtask

    // Start a divide, then abort it in BUSY iteration 10 via kill or reset
    task automatic abort_div(input logic use_rst);
        aluopE = OP_DIV; srcaE = 32'd1000; srcbE = 32'd3;
        #1;
        chk("abort_start_stall", stall_divE, 1'b1);
        step();
        repeat (9) step();
        if (use_rst) rst = 1'b1; else killE = 1'b1;
        #1;
        chk("abort_busy_stall", stall_divE, 1'b1);
        step();
        rst = 1'b0; killE = 1'b0; aluopE = OP_NOP;
        if (use_rst) begin hi_m = '0; lo_m = '0; end
        #1;
        chk("abort_stall_low", stall_divE, 1'b0);
        chk("abort_hi", hi_o, hi_m);
        chk("abort_lo", lo_o, lo_m);
    endtask

    initial begin
        logic [7:0] ops [8];
        logic [7:0] op;
        logic [31:0] a, b;
        ops = '{OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO, OP_DIV, OP_DIVU};

        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        chk("rst_stall", stall_divE, 1'b0);
        chk("rst_result", mdu_resultE, 32'd0);

        do_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFFE);
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi", hi_o, 32'h0000_0001);
        chk("multu_lo", lo_o, 32'hFFFF_FFFE);

        do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_m7_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_m7_hi", hi_o, 32'hFFFF_FFFF);
        do_div(OP_DIVU, 32'd7, 32'd2, 0);
        chk("divu7_lo", lo_o, 32'd3);
        chk("divu7_hi", hi_o, 32'd1);
        do_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_lo", lo_o, 32'h8000_0000);
        chk("div_ovf_hi", hi_o, 32'd0);
        do_op(OP_DIVU, 32'h1234, 32'd0, 1'b0);
        chk("div0_hi", hi_o, 32'h1234);
        chk("div0_lo", lo_o, 32'hFFFF_FFFF);

        abort_div(1'b0);
        abort_div(1'b1);

        do_op(OP_MTHI, 32'h0000_1234, 32'd0, 1'b0);
        do_op(OP_MFHI, 32'd0, 32'd0, 1'b0);
        do_op(OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1);
        chk("mtlo_kill_lo", lo_o, 32'd0);

        do_div(OP_DIVU, 32'd100, 32'd7, 3);
        chk("divu100_lo", lo_o, 32'd14);
        chk("divu100_hi", hi_o, 32'd2);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 7)];
            a  = $urandom();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom());
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            if ((op == OP_DIV || op == OP_DIVU) && b != 32'd0)
                do_div(op, a, b, int'($urandom_range(0, 2)));
            else
                do_op(op, a, b, ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
